// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver: FSM encodings, baud divider
// derivation and small helpers used by the top level.
package uart_rx_buffered_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef struct packed {
        logic frame_err;
        logic overflow;
    } rx_err_t;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic majority3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[1] & h[2]) | (h[0] & h[2]);
    endfunction

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read; reports a dropped write
// when a push arrives while full and no pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count,
    output logic             wr_drop
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept the write.
    always_comb begin
        pop     = rd_en && (count != '0);
        push    = wr_en && ((count != FULL) || pop);
        wr_drop = wr_en && !push;
    end

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with input synchroniser, majority-vote sampling and a small
// FWFT byte FIFO so a stalled consumer does not lose bytes.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int  CLK_FREQ   = 20_000_000,
    parameter int  BAUD       = 115200,
    parameter int  FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] fifo_count,
    output logic          frame_err,
    output logic          overflow
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       hist;
    logic             vote;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             half_tick;
    logic             bit_tick;
    logic             stop_good;
    logic             stop_bad;
    logic             drop;
    rx_err_t          err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            hist    <= 3'b111;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            hist    <= {hist[1:0], rx_s};
        end
    end

    always_comb begin
        vote      = majority3(hist);
        half_tick = (cnt == CNT_HALF);
        bit_tick  = (cnt == CNT_LAST);
        stop_good = (state == ST_STOP) && bit_tick && vote;
        stop_bad  = (state == ST_STOP) && bit_tick && !vote;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                // Start bit is confirmed half a bit in; a short low pulse is a glitch.
                ST_START: begin
                    if (half_tick) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= vote ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        state <= vote ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // A held-low line must return high before a new start bit is trusted.
                ST_BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_DATA) && bit_tick) begin
            shreg <= {vote, shreg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            err <= '{frame_err: stop_bad, overflow: drop};
        end
    end

    assign frame_err = err.frame_err;
    assign overflow  = err.overflow;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (stop_good),
        .wr_data  (shreg),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (fifo_count),
        .wr_drop  (drop)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: serial frames driven bit by bit, received
// bytes compared against a queue model of the FIFO.
module tb_uart_rx_buffered;

    localparam int BIT   = 173;
    localparam int DEPTH = 4;
    // Edges from the start-bit falling edge to the stop-bit sample edge:
    // 2 synchroniser flops, 1 idle detect edge, half bit, then 9 full bits.
    localparam int STOP_EDGE = 3 + BIT / 2 + 9 * BIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_FREQ   (20_000_000),
        .BAUD       (115200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
        if (frame_err && overflow) both_cnt++;
    end

    // Called on a negedge; drives one full 10-bit frame and leaves the line idle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_count !== 3'd0 ||
            frame_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h count=%0d fe=%b ov=%b required 0 0 0 0 0",
                     rd_valid, rd_data, fifo_count, frame_err, overflow);
        end
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_line: got count=%0d valid=%b required 0 0", fifo_count, rd_valid);
        end
    endtask

    task automatic test_single_byte();
        fork
            send_frame(8'h01, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                checks++;
                if (rd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_valid: got %b required 0", rd_valid);
                end
                @(negedge clk);
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 8'h01 || fifo_count !== 3'd1) begin
                    errors++;
                    $display("FAIL push_latency: got valid=%b data=%h count=%0d required 1 01 1",
                             rd_valid, rd_data, fifo_count);
                end
            end
        join
        repeat (20) @(negedge clk);
        do_pop();
        checks++;
        if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL pop_single: got valid=%b count=%0d required 0 0", rd_valid, fifo_count);
        end
        do_pop();
        checks++;
        if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL pop_empty: got valid=%b count=%0d required 0 0", rd_valid, fifo_count);
        end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || rd_valid !== 1'b0 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL glitch: got count=%0d valid=%b fe_pulses=%0d required 0 0 0",
                     fifo_count, rd_valid, fe_cnt - fe0);
        end
        send_frame(8'h5A, 1'b1);
        repeat (50) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h5A || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL after_glitch: got valid=%b data=%h count=%0d required 1 5a 1",
                     rd_valid, rd_data, fifo_count);
        end
        do_pop();
    endtask

    task automatic test_frame_error();
        int fe0;
        int ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (fe_cnt - fe0 != 1 || ov_cnt != ov0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL frame_err: got fe_pulses=%0d ov_pulses=%0d count=%0d required 1 0 0",
                     fe_cnt - fe0, ov_cnt - ov0, fifo_count);
        end
        send_frame(8'hA5, 1'b1);
        repeat (50) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || fifo_count !== 3'd1 || fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL after_break: got valid=%b data=%h count=%0d fe_pulses=%0d required 1 a5 1 1",
                     rd_valid, rd_data, fifo_count, fe_cnt - fe0);
        end
        do_pop();
    endtask

    task automatic test_overflow();
        int ov0;
        ov0 = ov_cnt;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1);
            repeat (10) @(negedge clk);
            if (model_q.size() < DEPTH) model_q.push_back(8'h10 + 8'(i));
            checks++;
            if (fifo_count !== 3'(model_q.size()) || ov_cnt - ov0 != (i == 4 ? 1 : 0)) begin
                errors++;
                $display("FAIL overflow_fill%0d: got count=%0d ov_pulses=%0d required %0d %0d",
                         i, fifo_count, ov_cnt - ov0, model_q.size(), (i == 4 ? 1 : 0));
            end
        end
        while (model_q.size() > 0) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
                errors++;
                $display("FAIL overflow_drain: got valid=%b data=%h required 1 %h",
                         rd_valid, rd_data, model_q[0]);
            end
            void'(model_q.pop_front());
            do_pop();
        end
    endtask

    task automatic test_push_pop_full();
        int ov0;
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_q.push_back(b);
            repeat (5) @(negedge clk);
        end
        ov0 = ov_cnt;
        fork
            send_frame(8'h20, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        void'(model_q.pop_front());
        model_q.push_back(8'h20);
        repeat (10) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL push_pop_full: got count=%0d ov_pulses=%0d required 4 0",
                     fifo_count, ov_cnt - ov0);
        end
        while (model_q.size() > 0) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
                errors++;
                $display("FAIL push_pop_drain: got valid=%b data=%h required 1 %h",
                         rd_valid, rd_data, model_q[0]);
            end
            void'(model_q.pop_front());
            do_pop();
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int ov0;
        int exp_ov;
        for (int it = 0; it < 8; it++) begin
            b = 8'($urandom_range(0, 255));
            if (model_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
                    errors++;
                    $display("FAIL rand_pop%0d: got valid=%b data=%h required 1 %h",
                             it, rd_valid, rd_data, model_q[0]);
                end
                void'(model_q.pop_front());
                do_pop();
            end
            ov0 = ov_cnt;
            exp_ov = (model_q.size() == DEPTH) ? 1 : 0;
            send_frame(b, 1'b1);
            repeat ($urandom_range(1, 60)) @(negedge clk);
            if (exp_ov == 0) model_q.push_back(b);
            checks++;
            if (fifo_count !== 3'(model_q.size()) || ov_cnt - ov0 != exp_ov) begin
                errors++;
                $display("FAIL rand_frame%0d: got count=%0d ov_pulses=%0d required %0d %0d",
                         it, fifo_count, ov_cnt - ov0, model_q.size(), exp_ov);
            end
        end
        while (model_q.size() > 0) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
                errors++;
                $display("FAIL rand_drain: got valid=%b data=%h required 1 %h",
                         rd_valid, rd_data, model_q[0]);
            end
            void'(model_q.pop_front());
            do_pop();
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0;
        int ov0;
        logic [7:0] partial;
        partial = 8'h3C;
        send_frame(8'h77, 1'b1);
        repeat (5) @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (BIT) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b data=%h count=%0d required 0 00 0",
                     rd_valid, rd_data, fifo_count);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        repeat (2 * BIT) @(negedge clk);
        send_frame(8'hFF, 1'b1);
        repeat (3 * BIT) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hFF || fifo_count !== 3'd1 ||
            fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL after_reset: got valid=%b data=%h count=%0d fe=%0d ov=%0d required 1 ff 1 0 0",
                     rd_valid, rd_data, fifo_count, fe_cnt - fe0, ov_cnt - ov0);
        end
        do_pop();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_push_pop_full();
        test_random();
        test_reset_mid_frame();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL err_exclusive: got %0d coincident pulses required 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
